display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Scan scheduler for the 4-digit multiplexed 7-segment display. Sequences the digit selector with a blanking gap between digits to suppress ghosting. Applies brightness PWM within each digit window and per-digit blinking for time-set feedback. Feeds the seg7 decoder (bcd) and the top-level selector/point outputs; replaces the free-running selector rotate.

Parameters:
DWELL_CYCLES, 27000, ON-window length per digit in clk cycles (1 ms at 27 MHz); must be >= 8
BLANK_CYCLES, 270, selector-off gap before each digit's ON window; must be >= 1
BLINK_CYCLES, 13500000, blink half-period in clk cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = scan runs; 0 = display dark, scan parked
digits  in  16  four BCD nibbles; [3:0] = digit 0 (min_u) .. [15:12] = digit 3 (hrs_d)
dots  in  4  decimal point per digit, bit i = digit i
blink_mask  in  4  bit i = 1: digit i blinks
brightness  in  3  duty select 0..7
selector  out  4  registered one-hot digit enable; 0 = all off
bcd  out  4  registered BCD value of the current digit
dot  out  1  registered decimal point of the current digit
digit_idx  out  2  current digit index
frame_tick  out  1  one-cycle pulse at the end of digit 3's ON window

Behaviour:
- Reset: state IDLE, digit_idx 0, phase counter 0, blink counter 0, blink_phase 0, selector 0, bcd 0, dot 0, frame_tick 0.
- FSM states: IDLE, BLANK, ON.
- IDLE: selector 0, counters held at 0. When enable=1, go to BLANK next cycle with count 0.
- BLANK: lasts exactly BLANK_CYCLES cycles with selector 0. On the last cycle:
  - latch bcd <= digits[idx], dot <= dots[idx], lit <= ((brightness+1)*DWELL_CYCLES)>>3
  - go to ON with count 0.
- ON: lasts exactly DWELL_CYCLES cycles.
  - selector = one-hot(idx) on ON cycles with count < lit, else 0.
  - brightness 7 = full window; brightness 0 = DWELL_CYCLES/8.
  - On the last ON cycle: idx <= idx+1 (3 wraps to 0), go to BLANK.
  - frame_tick=1 on the ON->BLANK transition cycle when idx==3; 0 otherwise.
- Period: per digit = BLANK_CYCLES + DWELL_CYCLES; frame = 4x that.
- Input sampling: digits, dots and brightness are sampled only at BLANK->ON. Changes mid-window take effect at the next digit window; no tearing.
- Blink:
  - Blink counter is free-running whenever reset is low, including in IDLE.
  - blink_phase toggles every BLINK_CYCLES cycles.
  - When blink_phase=1 and blink_mask[idx]=1, selector is forced 0 for the whole ON window. FSM timing is unaffected.
  - blink_mask is evaluated live each cycle.
- enable deasserted in any state: next cycle state IDLE, selector 0, idx 0, phase count 0, frame_tick 0. bcd and dot hold their last values. Re-enable always restarts at digit 0 with a full BLANK.
- Reset mid-ON: selector 0 on the next cycle; all state as at reset.
- BCD values > 9 pass through unchanged (the decoder blanks them).
- Count widths are sized from the parameters with $clog2; lit arithmetic is done at full width with no truncation before the >>3.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when the latched bcd for digit 3 is 0, selector stays 0 for digit 3's entire ON window. Timing and frame_tick are unchanged. Digits 0..2 are never suppressed.
- Undefined: digit 3 is displayed normally, including a zero.

Test Plan:
(Bench params: DWELL_CYCLES=16, BLANK_CYCLES=2, BLINK_CYCLES=64.)
1. Reset, then enable=1, brightness=7, digits=16'h4321, dots=4'b0100 -> selector sequence 0 x2, 0001 x16 (bcd=1, dot=0), 0 x2, 0010 x16 (bcd=2), 0 x2, 0100 x16 (bcd=3, dot=1), 0 x2, 1000 x16 (bcd=4); frame_tick pulses once every 72 cycles.
2. brightness=1 -> selector high 4 of 16 ON cycles (count 0..3) per digit; brightness=0 -> 2 cycles; brightness changed mid-window -> applies from the next digit only.
3. blink_mask=4'b0100 -> digit 2 selector 0 for every window while blink_phase=1 and normal while blink_phase=0; other digits and frame_tick period (72) unchanged.
4. digits changed from 16'h4321 to 16'h9876 at ON count 5 of digit 0 -> bcd stays 1 through that window; digit 1 window shows 7.
5. enable=0 at ON count 8 of digit 2 -> selector 0 next cycle, digit_idx 0; enable=1 -> 2 blank cycles, then digit 0 window. Repeat with reset pulse instead of enable -> same restart; bcd=0 after reset.
6. digits=16'h0123 with LEADING_ZERO_BLANK_EN defined -> selector never equals 1000, frame_tick still every 72 cycles; without macro -> 1000 asserted 16 cycles per frame with bcd=0.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-segment scan scheduler: blanking gap, PWM brightness, per-digit blink
// Optional: define LEADING_ZERO_BLANK_EN to keep digit 3 dark while its latched value is zero.
module display_scan_ctrl #(
    parameter int DWELL_CYCLES = 27000,
    parameter int BLANK_CYCLES = 270,
    parameter int BLINK_CYCLES = 13500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dots,
    input  logic [3:0]  blink_mask,
    input  logic [2:0]  brightness,
    output logic [3:0]  selector,
    output logic [3:0]  bcd,
    output logic        dot,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = CW + 4;
    localparam int BW      = $clog2(BLINK_CYCLES + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [PW-1:0] DWELL_P    = PW'(DWELL_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  lit_q, lit_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     bcd_q, bcd_d;
    logic           dot_q, dot_d;
    logic [3:0]     selector_q, selector_d;
    logic           frame_tick_q, frame_tick_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           blink_phase_q, blink_phase_d;
    logic [PW-1:0]  lit_prod;
    logic           show;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            lit_q         <= '0;
            idx_q         <= '0;
            bcd_q         <= '0;
            dot_q         <= 1'b0;
            selector_q    <= '0;
            frame_tick_q  <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lit_q         <= lit_d;
            idx_q         <= idx_d;
            bcd_q         <= bcd_d;
            dot_q         <= dot_d;
            selector_q    <= selector_d;
            frame_tick_q  <= frame_tick_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lit_d         = lit_q;
        idx_d         = idx_q;
        bcd_d         = bcd_q;
        dot_d         = dot_q;
        lit_prod      = '0;
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        // Snapshot display data once per window so mid-window edits never tear
                        state_d  = S_ON;
                        cnt_d    = '0;
                        bcd_d    = digits[{idx_q, 2'b00} +: 4];
                        dot_d    = dots[idx_q];
                        lit_prod = (PW'(brightness) + PW'(1)) * DWELL_P;
                        lit_d    = CW'(lit_prod >> 3);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_ON: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // Outputs are derived from next-state values so the registers line up with state_q
        show = (state_d == S_ON) && (cnt_d < lit_d) && !(blink_phase_d && blink_mask[idx_d]);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_d == 2'd3) && (bcd_d == 4'd0)) begin
            show = 1'b0;
        end
`endif
        selector_d   = show ? (4'b0001 << idx_d) : 4'b0000;
        frame_tick_d = (state_d == S_ON) && (cnt_d == DWELL_LAST) && (idx_d == 2'd3);
    end

    assign selector   = selector_q;
    assign bcd        = bcd_q;
    assign dot        = dot_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

    localparam int D     = 16;
    localparam int B     = 2;
    localparam int K     = 64;
    localparam int WIN   = D + B;
    localparam int FRAME = 4 * WIN;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [15:0] digits;
    logic [3:0]  dots, blink_mask;
    logic [2:0]  brightness;
    logic [3:0]  selector, bcd;
    logic        dot;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: position within the scan as a plain cycle count since scan start
    bit         m_run;
    int         m_t;
    int         m_blink;
    logic [3:0] m_bcd;
    logic       m_dot;
    int         m_lit;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B),
        .BLINK_CYCLES(K)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .digits    (digits),
        .dots      (dots),
        .blink_mask(blink_mask),
        .brightness(brightness),
        .selector  (selector),
        .bcd       (bcd),
        .dot       (dot),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        int dg;
        if (reset) begin
            m_run   = 1'b0;
            m_t     = 0;
            m_blink = 0;
            m_bcd   = 4'd0;
            m_dot   = 1'b0;
            m_lit   = 0;
        end else begin
            m_blink++;
            if (!enable) begin
                m_run = 1'b0;
                m_t   = 0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
            end
            if (m_run && (m_t % WIN) == B) begin
                dg    = (m_t / WIN) % 4;
                m_bcd = 4'((digits >> (4 * dg)) & 16'hF);
                m_dot = dots[dg];
                m_lit = ((int'(brightness) + 1) * D) / 8;
            end
        end
    endtask

    function automatic logic [3:0] exp_sel();
        int win;
        int dg;
        bit on;
        win = m_t % WIN;
        dg  = (m_t / WIN) % 4;
        if (!m_run || win < B) return 4'd0;
        on = (win - B) < m_lit;
        if (((m_blink / K) % 2) == 1 && blink_mask[dg]) on = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (dg == 3 && m_bcd == 4'd0) on = 1'b0;
`endif
        return on ? 4'(1 << dg) : 4'd0;
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_update();
            #1;
            cyc++;
            chk("m_selector", selector, exp_sel());
            chk("m_bcd", bcd, m_bcd);
            chk("m_dot", dot, m_dot);
            chk("m_digit_idx", digit_idx, m_run ? (m_t / WIN) % 4 : 0);
            chk("m_frame_tick", frame_tick,
                (m_run && (m_t % WIN) == WIN - 1 && (m_t / WIN) % 4 == 3) ? 1 : 0);
        end
    endtask

    task automatic restart(input logic [15:0] dg, input logic [2:0] br);
        enable = 1'b0;
        tick();
        digits     = dg;
        brightness = br;
        enable     = 1'b1;
    endtask

    typedef struct {
        logic [3:0] sel;
        int         len;
        logic [3:0] bcd;
        logic       dot;
        bit         has_val;
    } seg_t;

    typedef struct {
        logic [2:0] br;
        int         on_cycles;
    } br_vec_t;

    seg_t    segs[8];
    br_vec_t bv[5];

    initial begin
        int hi, last, pos, ft_at, ft_cnt, lit2, dark2, oth_dark, d3_hits;
        logic [3:0] d3_bcd;

        segs[0] = '{4'b0000, B, 4'd0, 1'b0, 1'b0};
        segs[1] = '{4'b0001, D, 4'd1, 1'b0, 1'b1};
        segs[2] = '{4'b0000, B, 4'd0, 1'b0, 1'b0};
        segs[3] = '{4'b0010, D, 4'd2, 1'b0, 1'b1};
        segs[4] = '{4'b0000, B, 4'd0, 1'b0, 1'b0};
        segs[5] = '{4'b0100, D, 4'd3, 1'b1, 1'b1};
        segs[6] = '{4'b0000, B, 4'd0, 1'b0, 1'b0};
        segs[7] = '{4'b1000, D, 4'd4, 1'b0, 1'b1};

        bv[0] = '{3'd7, 16};
        bv[1] = '{3'd3, 8};
        bv[2] = '{3'd1, 4};
        bv[3] = '{3'd0, 2};
        bv[4] = '{3'd5, 12};

        reset      = 1'b1;
        enable     = 1'b0;
        digits     = 16'h4321;
        dots       = 4'b0100;
        blink_mask = 4'b0000;
        brightness = 3'd7;
        tick(2);
        chk("rst_selector", selector, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_dot", dot, 0);
        chk("rst_digit_idx", digit_idx, 0);
        chk("rst_frame_tick", frame_tick, 0);

        // Basic frame sequence
        reset  = 1'b0;
        enable = 1'b1;
        pos    = 0;
        ft_at  = -1;
        ft_cnt = 0;
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < segs[s].len; c++) begin
                tick();
                chk("t1_selector", selector, segs[s].sel);
                if (segs[s].has_val) begin
                    chk("t1_bcd", bcd, segs[s].bcd);
                    chk("t1_dot", dot, segs[s].dot);
                end
                if (frame_tick) begin
                    ft_at = pos;
                    ft_cnt++;
                end
                pos++;
            end
        end
        chk("t1_frame_tick_pos", ft_at, FRAME - 1);
        chk("t1_frame_tick_cnt", ft_cnt, 1);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (frame_tick) ft_at = pos;
            pos++;
        end
        chk("t1_frame_period", ft_at, 2 * FRAME - 1);

        // Brightness duty table
        for (int i = 0; i < 5; i++) begin
            restart(16'h4321, bv[i].br);
            hi   = 0;
            last = -1;
            for (int c = 0; c < WIN; c++) begin
                tick();
                if (selector != 4'd0) begin
                    hi++;
                    last = c;
                end
            end
            chk("t2_on_cycles", hi, bv[i].on_cycles);
            chk("t2_last_on_pos", last, B + bv[i].on_cycles - 1);
        end

        // Brightness change mid-window applies from the next digit
        restart(16'h4321, 3'd7);
        hi = 0;
        for (int c = 0; c < WIN; c++) begin
            if (c == 5) brightness = 3'd1;
            tick();
            if (selector != 4'd0) hi++;
        end
        chk("t2_mid_cur_window", hi, 16);
        hi = 0;
        for (int c = 0; c < WIN; c++) begin
            tick();
            if (selector != 4'd0) hi++;
        end
        chk("t2_mid_next_window", hi, 4);

        // Blink on digit 2
        blink_mask = 4'b0100;
        restart(16'h4321, 3'd7);
        lit2 = 0; dark2 = 0; oth_dark = 0; ft_cnt = 0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            tick();
            pos = c % FRAME;
            if ((pos % WIN) >= B) begin
                if (pos / WIN == 2) begin
                    if (selector == 4'b0100) lit2++;
                    if (selector == 4'b0000) dark2++;
                end else if (selector == 4'b0000) begin
                    oth_dark++;
                end
            end
            if (frame_tick) begin
                ft_cnt++;
                chk("t3_frame_tick_pos", pos, FRAME - 1);
            end
        end
        chk("t3_digit2_lit_seen", lit2 > 0, 1);
        chk("t3_digit2_dark_seen", dark2 > 0, 1);
        chk("t3_other_digits_dark", oth_dark, 0);
        chk("t3_frame_tick_cnt", ft_cnt, 4);
        blink_mask = 4'b0000;

        // Digits change mid-window: no tearing
        restart(16'h4321, 3'd7);
        tick(8);
        digits = 16'h9876;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t4_bcd_held", bcd, 4'd1);
        end
        tick(3);
        chk("t4_next_bcd", bcd, 4'd7);
        chk("t4_next_sel", selector, 4'b0010);

        // Enable drop mid-window, then restart
        restart(16'h4321, 3'd7);
        tick(47);
        chk("t5_pre_sel", selector, 4'b0100);
        enable = 1'b0;
        tick();
        chk("t5_off_sel", selector, 0);
        chk("t5_off_idx", digit_idx, 0);
        chk("t5_off_ft", frame_tick, 0);
        chk("t5_off_bcd_hold", bcd, 4'd3);
        enable = 1'b1;
        for (int c = 0; c < B; c++) begin
            tick();
            chk("t5_re_blank", selector, 0);
        end
        tick();
        chk("t5_re_sel", selector, 4'b0001);
        chk("t5_re_bcd", bcd, 4'd1);

        // Reset pulse mid-window
        restart(16'h4321, 3'd7);
        tick(47);
        reset = 1'b1;
        tick();
        chk("t5_rst_sel", selector, 0);
        chk("t5_rst_bcd", bcd, 0);
        chk("t5_rst_idx", digit_idx, 0);
        reset = 1'b0;
        for (int c = 0; c < B; c++) begin
            tick();
            chk("t5_rst_blank", selector, 0);
        end
        tick();
        chk("t5_rst_re_sel", selector, 4'b0001);
        chk("t5_rst_re_bcd", bcd, 4'd1);

        // Leading zero on digit 3
        restart(16'h0123, 3'd7);
        d3_hits = 0; ft_cnt = 0; d3_bcd = 4'hF;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (selector == 4'b1000) d3_hits++;
            if (frame_tick) ft_cnt++;
            if (c == 3 * WIN + B) d3_bcd = bcd;
        end
        chk("t6_d3_bcd", d3_bcd, 4'd0);
        chk("t6_frame_tick_cnt", ft_cnt, 2);
`ifdef LEADING_ZERO_BLANK_EN
        chk("t6_d3_lit_cycles", d3_hits, 0);
`else
        chk("t6_d3_lit_cycles", d3_hits, 2 * D);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)   digits     = 16'($urandom);
            if ($urandom_range(0, 9) == 0)   dots       = 4'($urandom);
            if ($urandom_range(0, 19) == 0)  brightness = 3'($urandom);
            if ($urandom_range(0, 49) == 0)  blink_mask = 4'($urandom);
            enable = ($urandom_range(0, 299) != 0);
            reset  = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
